// File: rtl/read_for_bram_controller_pkg.sv
// Shared types and defaults for the BRAM readout controller.
// The FSM states and default geometry live here so the top and bench agree.
package bram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } rd_state_t;

    localparam int DEF_DATA_W     = 64;
    localparam int DEF_RD_LATENCY = 2;

endpackage

// File: rtl/read_for_bram_controller_if.sv
// BRAM read port plus outgoing valid/ready word stream.
// master is the controller side, slave is the BRAM/consumer side.
interface read_for_bram_controller_if #(
    parameter int DATA_W = 64
) ();

    logic              read_en;
    logic [31:0]       read_addr;
    logic [DATA_W-1:0] bram_rdata;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;

    modport master (
        output read_en,
        output read_addr,
        input  bram_rdata,
        output m_data,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  read_en,
        input  read_addr,
        output bram_rdata,
        input  m_data,
        input  m_valid,
        output m_ready
    );

endinterface

// File: rtl/bram_rd_skid_fifo.sv
// Show-ahead skid FIFO absorbing BRAM words already in flight.
// Output data is forced to zero while empty so reset leaves m_data clean.
module bram_rd_skid_fifo #(
    parameter int DATA_W     = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              wr_en,
    input  logic [DATA_W-1:0]                 wr_data,
    input  logic                              rd_en,
    output logic [DATA_W-1:0]                 rd_data,
    output logic                              valid,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_wr;
    logic              do_rd;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign valid   = (count != '0);
    assign do_wr   = wr_en && (count != CW'(FIFO_DEPTH));
    assign do_rd   = rd_en && valid;
    assign rd_data = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= ptr_inc(wr_ptr);
            if (do_rd) rd_ptr <= ptr_inc(rd_ptr);
            unique case ({do_wr, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/read_for_bram_controller.sv
// Streams wpp*num_pixels BRAM words out through a credit-limited skid FIFO.
// Reads are only launched when the FIFO can hold every word still in flight.
module read_for_bram_controller
    import bram_ctrl_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int RD_LATENCY = DEF_RD_LATENCY,
    parameter int FIFO_DEPTH = RD_LATENCY + 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] OFM_C,
    input  logic [15:0] num_pixels,
    output logic        busy,
    output logic        done,
    read_for_bram_controller_if.master bus
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    rd_state_t             state;
    rd_state_t             state_nx;
    logic [15:0]           wpp_in;
    logic [15:0]           wpp_q;
    logic [15:0]           npix_q;
    logic [15:0]           pix_q;
    logic [31:0]           addr_q;
    logic [31:0]           total_q;
    logic [31:0]           rd_cnt_q;
    logic [RD_LATENCY-1:0] vld_sr;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_valid;
    logic                  pass_ok;
    logic                  credit_ok;
    logic                  issue;
    logic                  addr_wrap;
    logic                  last_read;

    assign wpp_in    = OFM_C >> 3;
    assign pass_ok   = (wpp_in != '0) && (num_pixels != '0);
    // vld_sr counts every word between read strobe and FIFO write
    assign credit_ok = (int'(fifo_count) + $countones(vld_sr)) < FIFO_DEPTH;
    assign issue     = (state == RUN) && credit_ok;
    assign addr_wrap = (addr_q == {16'd0, wpp_q - 16'd1});
    assign last_read = issue && addr_wrap
                     && (pix_q == npix_q - 16'd1)
                     && (rd_cnt_q == total_q - 32'd1);

    assign busy          = (state != IDLE);
    assign done          = (state == DONE);
    assign bus.read_en   = issue;
    assign bus.read_addr = addr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = pass_ok ? RUN : DONE;
            RUN:     if (last_read) state_nx = DRAIN;
            DRAIN:   if (vld_sr == '0 && fifo_count == '0) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wpp_q    <= '0;
            npix_q   <= '0;
            total_q  <= '0;
            addr_q   <= '0;
            pix_q    <= '0;
            rd_cnt_q <= '0;
        end else if (state == IDLE && start) begin
            wpp_q    <= wpp_in;
            npix_q   <= num_pixels;
            total_q  <= 32'(wpp_in) * 32'(num_pixels);
            addr_q   <= '0;
            pix_q    <= '0;
            rd_cnt_q <= '0;
        end else if (issue) begin
            rd_cnt_q <= rd_cnt_q + 32'd1;
            if (addr_wrap) begin
                addr_q <= '0;
                pix_q  <= pix_q + 16'd1;
            end else begin
                addr_q <= addr_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_sr <= '0;
        end else begin
            vld_sr[0] <= issue;
            for (int i = 1; i < RD_LATENCY; i++) vld_sr[i] <= vld_sr[i-1];
        end
    end

    bram_rd_skid_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (vld_sr[RD_LATENCY-1]),
        .wr_data (bus.bram_rdata),
        .rd_en   (bus.m_ready),
        .rd_data (bus.m_data),
        .valid   (fifo_valid),
        .count   (fifo_count)
    );

    assign bus.m_valid = fifo_valid;

endmodule
